// File: rtl/input_mems_pingpong_pkg.sv
// input_mems_pingpong_pkg: load-state encoding and width helpers shared by the ping-pong input buffer.
package input_mems_pingpong_pkg;
    typedef enum logic [1:0] {IDLE, LOAD_W, LOAD_B, LOAD_X} load_state_e;
    function automatic int k_bits(input int maxk);
        return $clog2(maxk + 1);
    endfunction
    function automatic int xa_bits(input int r, input int c);
        return $clog2(r * c);
    endfunction
    function automatic int wa_bits(input int maxk);
        return $clog2(maxk * maxk);
    endfunction
endpackage

// File: rtl/input_mems_pingpong_mem.sv
// input_mems_pingpong_mem: single-port memory with write enable and registered read.
module input_mems_pingpong_mem #(
    parameter int DW = 24,
    parameter int DEPTH = 16,
    parameter int AW = 4
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] addr,
    input  logic [DW-1:0] wdata,
    output logic [DW-1:0] rdata
);
    logic [DW-1:0] mem [DEPTH];
    logic [DW-1:0] rdata_q;
    always_ff @(posedge clk) begin
        if (we) mem[addr] <= wdata;
        rdata_q <= mem[addr];
    end
    assign rdata = rdata_q;
endmodule

// File: rtl/input_mems_pingpong.sv
// input_mems_pingpong: AXI-stream loader filling W, B and two ping-pong X banks;
// one bank is loaded while the other is held for compute.
module input_mems_pingpong
    import input_mems_pingpong_pkg::*;
#(
    parameter int INW = 24,
    parameter int R = 9,
    parameter int C = 8,
    parameter int MAXK = 4,
    localparam int K_BITS = k_bits(MAXK),
    localparam int XA = xa_bits(R, C),
    localparam int WA = wa_bits(MAXK)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [INW-1:0]        AXIS_TDATA,
    input  logic                  AXIS_TVALID,
    output logic                  AXIS_TREADY,
    input  logic [K_BITS:0]       AXIS_TUSER,
    output logic                  inputs_loaded,
    input  logic                  compute_finished,
    output logic [K_BITS-1:0]     K,
    output logic signed [INW-1:0] B,
    input  logic [XA-1:0]         X_read_addr,
    output logic signed [INW-1:0] X_data,
    input  logic [WA-1:0]         W_read_addr,
    output logic signed [INW-1:0] W_data
);
    localparam int IW = (XA > WA) ? XA : WA;
    load_state_e state_q, state_d;
    logic [IW-1:0] idx_q, idx_d;
    logic wr_bank_q, wr_bank_d, rd_bank_q, rd_bank_d;
    logic [1:0] full_q, full_d;
    logic [K_BITS-1:0] k_q, k_d, k_in;
    logic [INW-1:0] b_q, b_d;
    logic new_w, ready, xfer, w_we, x_we, w_last, x_last;
    logic [INW-1:0] w_rdata;
    logic [INW-1:0] x_rdata [2];
    assign new_w = AXIS_TUSER[0];
    assign k_in = AXIS_TUSER[K_BITS:1];
    // A new W/B set may only start once no bank still depends on the current one.
    assign ready = (state_q != IDLE) || (!full_q[wr_bank_q] && (!new_w || full_q == 2'b00));
    assign AXIS_TREADY = !reset && ready;
    assign xfer = AXIS_TVALID && AXIS_TREADY;
    always_comb begin
        state_d = state_q;
        idx_d = idx_q;
        wr_bank_d = wr_bank_q;
        rd_bank_d = rd_bank_q;
        full_d = full_q;
        k_d = k_q;
        b_d = b_q;
        w_we = 1'b0;
        x_we = 1'b0;
        w_last = idx_q == IW'(int'(k_q) * int'(k_q) - 1);
        x_last = idx_q == IW'(R * C - 1);
        if (xfer) begin
            case (state_q)
                IDLE: begin
                    if (new_w) begin
                        w_we = 1'b1;
                        k_d = (k_in == '0 || int'(k_in) > MAXK) ? K_BITS'(MAXK) : k_in;
                        state_d = (k_d == K_BITS'(1)) ? LOAD_B : LOAD_W;
                        idx_d = (k_d == K_BITS'(1)) ? '0 : IW'(1);
                    end else begin
                        x_we = 1'b1;
                        state_d = LOAD_X;
                        idx_d = IW'(1);
                    end
                end
                LOAD_W: begin
                    w_we = 1'b1;
                    state_d = w_last ? LOAD_B : LOAD_W;
                    idx_d = w_last ? '0 : idx_q + 1'b1;
                end
                LOAD_B: begin
                    b_d = AXIS_TDATA;
                    state_d = LOAD_X;
                end
                default: begin
                    x_we = 1'b1;
                    state_d = x_last ? IDLE : LOAD_X;
                    idx_d = x_last ? '0 : idx_q + 1'b1;
                    if (x_last) begin
                        full_d[wr_bank_q] = 1'b1;
                        wr_bank_d = !wr_bank_q;
                    end
                end
            endcase
        end
        if (compute_finished && full_q[rd_bank_q]) begin
            full_d[rd_bank_q] = 1'b0;
            rd_bank_d = !rd_bank_q;
        end
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            idx_q <= '0;
            wr_bank_q <= 1'b0;
            rd_bank_q <= 1'b0;
            full_q <= 2'b00;
            k_q <= '0;
            b_q <= '0;
        end else begin
            state_q <= state_d;
            idx_q <= idx_d;
            wr_bank_q <= wr_bank_d;
            rd_bank_q <= rd_bank_d;
            full_q <= full_d;
            k_q <= k_d;
            b_q <= b_d;
        end
    end
    input_mems_pingpong_mem #(.DW(INW), .DEPTH(MAXK * MAXK), .AW(WA)) u_w_mem (
        .clk(clk),
        .we(w_we),
        .addr(w_we ? idx_q[WA-1:0] : W_read_addr),
        .wdata(AXIS_TDATA),
        .rdata(w_rdata)
    );
    for (genvar b = 0; b < 2; b++) begin : g_x
        logic bank_we;
        assign bank_we = x_we && (wr_bank_q == 1'(b));
        input_mems_pingpong_mem #(.DW(INW), .DEPTH(R * C), .AW(XA)) u_x_mem (
            .clk(clk),
            .we(bank_we),
            .addr(bank_we ? idx_q[XA-1:0] : X_read_addr),
            .wdata(AXIS_TDATA),
            .rdata(x_rdata[b])
        );
    end
    assign inputs_loaded = full_q[rd_bank_q];
    assign K = k_q;
    assign B = b_q;
    assign W_data = w_rdata;
    assign X_data = x_rdata[rd_bank_q];
endmodule

// File: tb/tb_input_mems_pingpong.sv
// tb_input_mems_pingpong: directed scenario tests for the ping-pong input buffer.
module tb_input_mems_pingpong;
    logic clk = 1'b0;
    logic reset = 1'b1;
    logic [23:0] AXIS_TDATA = '0;
    logic AXIS_TVALID = 1'b0;
    logic AXIS_TREADY;
    logic [3:0] AXIS_TUSER = '0;
    logic inputs_loaded;
    logic compute_finished = 1'b0;
    logic [2:0] K;
    logic signed [23:0] B;
    logic [6:0] X_read_addr = '0;
    logic signed [23:0] X_data;
    logic [3:0] W_read_addr = '0;
    logic signed [23:0] W_data;
    int checks = 0;
    int errors = 0;
    int st, tot;

    always #5 clk = ~clk;

    input_mems_pingpong dut (
        .clk(clk), .reset(reset),
        .AXIS_TDATA(AXIS_TDATA), .AXIS_TVALID(AXIS_TVALID), .AXIS_TREADY(AXIS_TREADY),
        .AXIS_TUSER(AXIS_TUSER), .inputs_loaded(inputs_loaded), .compute_finished(compute_finished),
        .K(K), .B(B), .X_read_addr(X_read_addr), .X_data(X_data),
        .W_read_addr(W_read_addr), .W_data(W_data)
    );

    // Hold one word valid until accepted; returns #1 after the accepting edge with TVALID still high.
    task automatic xfer(input logic [23:0] d, input logic [3:0] u, output int stalls);
        AXIS_TDATA = d;
        AXIS_TUSER = u;
        AXIS_TVALID = 1'b1;
        stalls = 0;
        while (AXIS_TREADY !== 1'b1 && stalls < 500) begin
            @(posedge clk); #1;
            stalls++;
        end
        if (stalls >= 500) begin
            checks++; errors++;
            $display("FAIL xfer_timeout data %0d tready %b exp 1", d, AXIS_TREADY);
        end
        @(posedge clk); #1;
    endtask

    task automatic load_x(input int base, output int total);
        total = 0;
        for (int i = 0; i < 72; i++) begin
            xfer(24'(base + i), 4'b0000, st);
            total += st;
        end
        AXIS_TVALID = 1'b0;
    endtask

    task automatic pulse_finished();
        compute_finished = 1'b1;
        @(posedge clk); #1;
        compute_finished = 1'b0;
    endtask

    task automatic test_reset();
        repeat (2) @(posedge clk);
        #1;
        checks++; if (AXIS_TREADY !== 1'b0) begin errors++; $display("FAIL rst_tready got %b exp 0", AXIS_TREADY); end
        checks++; if (inputs_loaded !== 1'b0) begin errors++; $display("FAIL rst_loaded got %b exp 0", inputs_loaded); end
        checks++; if (K !== 3'd0) begin errors++; $display("FAIL rst_k got %0d exp 0", K); end
        checks++; if (B !== 24'd0) begin errors++; $display("FAIL rst_b got %0d exp 0", B); end
        reset = 1'b0;
        #1;
        checks++; if (AXIS_TREADY !== 1'b1) begin errors++; $display("FAIL rst_tready_after got %b exp 1", AXIS_TREADY); end
    endtask

    task automatic test_load();
        for (int i = 1; i <= 9; i++) xfer(24'(i), {3'd3, 1'b1}, st);
        xfer(24'hFFFFFB, 4'b0000, st);
        for (int i = 0; i < 71; i++) xfer(24'(i), 4'b0000, st);
        checks++; if (inputs_loaded !== 1'b0) begin errors++; $display("FAIL load_early got %b exp 0", inputs_loaded); end
        xfer(24'd71, 4'b0000, st);
        AXIS_TVALID = 1'b0;
        checks++; if (inputs_loaded !== 1'b1) begin errors++; $display("FAIL load_done got %b exp 1", inputs_loaded); end
        checks++; if (K !== 3'd3) begin errors++; $display("FAIL load_k got %0d exp 3", K); end
        checks++; if (B !== 24'hFFFFFB) begin errors++; $display("FAIL load_b got %0d exp -5", B); end
        W_read_addr = 4'd8;
        X_read_addr = 7'd71;
        @(posedge clk); #1;
        checks++; if (W_data !== 24'd9) begin errors++; $display("FAIL load_w8 got %0d exp 9", W_data); end
        checks++; if (X_data !== 24'd71) begin errors++; $display("FAIL load_x71 got %0d exp 71", X_data); end
    endtask

    task automatic test_pingpong();
        load_x(100, tot);
        checks++; if (tot !== 0) begin errors++; $display("FAIL pp_stalls got %0d exp 0", tot); end
        checks++; if (inputs_loaded !== 1'b1) begin errors++; $display("FAIL pp_loaded got %b exp 1", inputs_loaded); end
        checks++; if (X_data !== 24'd71) begin errors++; $display("FAIL pp_undisturbed got %0d exp 71", X_data); end
    endtask

    task automatic test_both_full();
        AXIS_TDATA = 24'd200;
        AXIS_TUSER = 4'b0000;
        AXIS_TVALID = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            checks++; if (AXIS_TREADY !== 1'b0) begin errors++; $display("FAIL full_stall%0d got %b exp 0", i, AXIS_TREADY); end
        end
        X_read_addr = 7'd0;
        pulse_finished();
        checks++; if (X_data !== 24'd100) begin errors++; $display("FAIL full_swap_x0 got %0d exp 100", X_data); end
        checks++; if (inputs_loaded !== 1'b1) begin errors++; $display("FAIL full_swap_loaded got %b exp 1", inputs_loaded); end
        checks++; if (AXIS_TREADY !== 1'b1) begin errors++; $display("FAIL full_accept got %b exp 1", AXIS_TREADY); end
        load_x(200, tot);
        checks++; if (tot !== 0) begin errors++; $display("FAIL full_reload_stalls got %0d exp 0", tot); end
    endtask

    task automatic test_simultaneous();
        pulse_finished();
        checks++; if (X_data !== 24'd200) begin errors++; $display("FAIL sim_bank0_x0 got %0d exp 200", X_data); end
        for (int i = 0; i < 71; i++) xfer(24'(300 + i), 4'b0000, st);
        AXIS_TDATA = 24'd371;
        compute_finished = 1'b1;
        checks++; if (AXIS_TREADY !== 1'b1) begin errors++; $display("FAIL sim_tready got %b exp 1", AXIS_TREADY); end
        @(posedge clk); #1;
        AXIS_TVALID = 1'b0;
        compute_finished = 1'b0;
        checks++; if (inputs_loaded !== 1'b1) begin errors++; $display("FAIL sim_loaded got %b exp 1", inputs_loaded); end
        X_read_addr = 7'd5;
        @(posedge clk); #1;
        checks++; if (X_data !== 24'd305) begin errors++; $display("FAIL sim_new_bank got %0d exp 305", X_data); end
    endtask

    task automatic test_new_w_stall();
        AXIS_TDATA = 24'd50;
        AXIS_TUSER = {3'd2, 1'b1};
        AXIS_TVALID = 1'b1;
        W_read_addr = 4'd8;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            checks++; if (AXIS_TREADY !== 1'b0) begin errors++; $display("FAIL neww_stall%0d got %b exp 0", i, AXIS_TREADY); end
        end
        checks++; if (K !== 3'd3) begin errors++; $display("FAIL neww_k_held got %0d exp 3", K); end
        checks++; if (B !== 24'hFFFFFB) begin errors++; $display("FAIL neww_b_held got %0d exp -5", B); end
        checks++; if (W_data !== 24'd9) begin errors++; $display("FAIL neww_w_held got %0d exp 9", W_data); end
        pulse_finished();
        checks++; if (AXIS_TREADY !== 1'b1) begin errors++; $display("FAIL neww_release got %b exp 1", AXIS_TREADY); end
        for (int i = 0; i < 4; i++) xfer(24'(50 + i), {3'd2, 1'b1}, st);
        xfer(24'd7, 4'b0000, st);
        load_x(500, tot);
        checks++; if (K !== 3'd2) begin errors++; $display("FAIL neww_k got %0d exp 2", K); end
        checks++; if (B !== 24'd7) begin errors++; $display("FAIL neww_b got %0d exp 7", B); end
        W_read_addr = 4'd3;
        @(posedge clk); #1;
        checks++; if (W_data !== 24'd53) begin errors++; $display("FAIL neww_w3 got %0d exp 53", W_data); end
        pulse_finished();
        checks++; if (inputs_loaded !== 1'b0) begin errors++; $display("FAIL neww_empty got %b exp 0", inputs_loaded); end
    endtask

    task automatic test_mid_reset();
        xfer(24'd1000, {3'd0, 1'b1}, st);
        checks++; if (K !== 3'd4) begin errors++; $display("FAIL k0_maps_maxk got %0d exp 4", K); end
        for (int i = 1; i < 20; i++) xfer(24'(1000 + i), {3'd0, 1'b1}, st);
        AXIS_TVALID = 1'b0;
        reset = 1'b1;
        @(posedge clk); #1;
        checks++; if (AXIS_TREADY !== 1'b0) begin errors++; $display("FAIL mr_tready_rst got %b exp 0", AXIS_TREADY); end
        reset = 1'b0;
        #1;
        checks++; if (inputs_loaded !== 1'b0) begin errors++; $display("FAIL mr_loaded got %b exp 0", inputs_loaded); end
        checks++; if (AXIS_TREADY !== 1'b1) begin errors++; $display("FAIL mr_tready got %b exp 1", AXIS_TREADY); end
        checks++; if (K !== 3'd0) begin errors++; $display("FAIL mr_k got %0d exp 0", K); end
        for (int i = 0; i < 4; i++) xfer(24'(60 + i), {3'd2, 1'b1}, st);
        xfer(24'hFFFFFF, 4'b0000, st);
        load_x(400, tot);
        checks++; if (inputs_loaded !== 1'b1) begin errors++; $display("FAIL mr_done got %b exp 1", inputs_loaded); end
        checks++; if (K !== 3'd2) begin errors++; $display("FAIL mr_k2 got %0d exp 2", K); end
        checks++; if (B !== 24'hFFFFFF) begin errors++; $display("FAIL mr_b got %0d exp -1", B); end
        W_read_addr = 4'd3;
        X_read_addr = 7'd10;
        @(posedge clk); #1;
        checks++; if (W_data !== 24'd63) begin errors++; $display("FAIL mr_w3 got %0d exp 63", W_data); end
        checks++; if (X_data !== 24'd410) begin errors++; $display("FAIL mr_x10 got %0d exp 410", X_data); end
    endtask

    initial begin
        test_reset();
        test_load();
        test_pingpong();
        test_both_full();
        test_simultaneous();
        test_new_w_stall();
        test_mid_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/input_mems_pingpong.md
INPUT_MEMS_PINGPONG -- requirements
Module: input_mems_pingpong

Interface
REQ-001 SHALL have parameter INW, default 24, meaning data width of W, B and X words.
REQ-002 SHALL have parameter R, default 9, meaning rows of X.
REQ-003 SHALL have parameter C, default 8, meaning columns of X.
REQ-004 SHALL have parameter MAXK, default 4, meaning largest filter size; K_BITS=$clog2(MAXK+1), XA=$clog2(R*C), WA=$clog2(MAXK*MAXK).
REQ-005 SHALL have ports: clk in 1 clock; reset in 1 reset, synchronous, active-high.
REQ-006 AXIS_TDATA in INW stream data; AXIS_TVALID in 1; AXIS_TREADY out 1; AXIS_TUSER in K_BITS+1, [K_BITS:1]=K, [0]=new_W.
REQ-007 inputs_loaded out 1, compute bank holds a complete X plus valid W/B; compute_finished in 1, releases compute bank.
REQ-008 K out K_BITS current filter size; B out INW signed bias.
REQ-009 X_read_addr in XA; X_data out INW signed; W_read_addr in WA; W_data out INW signed.

Function
REQ-010 SHALL hold two X banks (R*C words each), one W memory (MAXK*MAXK words), one B register.
REQ-011 SHALL track load bank pointer wr_bank, compute bank pointer rd_bank, per-bank full flag.
REQ-012 Load FSM states: IDLE, LOAD_W, LOAD_B, LOAD_X; transfer = TVALID && TREADY.
REQ-013 IDLE: TREADY=1 only if full[wr_bank]=0 and (new_W=0 or no bank full); else TREADY=0.
REQ-014 IDLE transfer with new_W=1: latch K, write W[0], -> LOAD_W (K=1: -> LOAD_B).
REQ-015 IDLE transfer with new_W=0: write X[wr_bank][0], -> LOAD_X.
REQ-016 LOAD_W: TREADY=1, write W[idx]; after index K*K-1 -> LOAD_B.
REQ-017 LOAD_B: TREADY=1, latch B -> LOAD_X at X index 0.
REQ-018 LOAD_X: TREADY=1, write X[wr_bank][idx]; at idx R*C-1 set full[wr_bank], toggle wr_bank, -> IDLE.
REQ-019 TUSER_K of 0 or >MAXK SHALL be stored as MAXK.
REQ-020 inputs_loaded = full[rd_bank], combinational from registers.
REQ-021 compute_finished while inputs_loaded=1: clear full[rd_bank], toggle rd_bank next cycle; ignored when inputs_loaded=0.
REQ-022 Simultaneous last X write and compute_finished: both take effect same edge; X of other bank remains valid.
REQ-023 X_data from bank rd_bank, W_data from W memory, both registered, 1-cycle read latency.
REQ-024 W and B SHALL NOT change while any bank full; new_W packets stall at IDLE until both banks empty.
REQ-025 Reads during loading of the other bank SHALL not be disturbed (separate bank ports).

Reset
REQ-026 Reset: state IDLE, indices 0, wr_bank=rd_bank=0, full flags 0, K=0, B=0, TREADY=0 during reset cycle, inputs_loaded=0.
REQ-027 Reset mid-packet SHALL discard partial load; memory contents undefined but never flagged full.

Structure
REQ-028 Shared package SHALL hold the load-state enum and K_BITS/address-width helper functions.
REQ-029 One sub-module: memory (single-port, registered read, write enable) instantiated three times: W, X bank 0, X bank 1.

Verification
REQ-030 K=3, new_W=1, W=1..9, B=-5, X=0..71 -> inputs_loaded high cycle after 82nd transfer; K=3, B=-5; read W[8]=9, X[71]=71 one cycle after address.
REQ-031 During compute of bank 0, stream new_W=0 X=100..171 -> accepted without stall, bank 1 full; compute_finished -> next cycle X[0]=100.
REQ-032 Both banks full, TVALID=1 -> TREADY=0 until compute_finished, then accepts.
REQ-033 Bank full, new_W=1 packet presented -> TREADY=0 until both banks released; W/B unchanged meanwhile.
REQ-034 Last X transfer and compute_finished same cycle -> inputs_loaded stays 1, rd_bank toggles, data from newly filled bank.
REQ-035 Reset after 20 W words -> inputs_loaded=0, TREADY=1 after reset, fresh packet K=2 loads correctly.
